multi_counter_rsp_fifo: RTL and testbench

//  Downstream stage of the multi-counter pipeline: captures query responses
//  (status_pass & status_qry) emitted unthrottled by the counter engine and

---
 rtl/multi_counter_rsp_fifo.sv | 110 +++++++++++
 tb/tb_multi_counter_rsp_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_counter_rsp_fifo.sv
// Query-response FIFO behind the counter engine, with overflow tracking.
// Optional saturating drop counter: define MULTI_COUNTER_RSP_DROP_CNT_EN.
module multi_counter_rsp_fifo #(
  parameter int DEPTH      = 8,
  parameter int CNTRS_N    = 256,
  parameter int CNTRS_W    = 32,
  parameter int CNTRS_ID_W = $clog2(CNTRS_N),
  parameter int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  status_pass,
  input  logic                  status_qry,
  input  logic [CNTRS_ID_W-1:0] status_id,
  input  logic [CNTRS_W-1:0]    status_dat,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [CNTRS_ID_W-1:0] rsp_id,
  output logic [CNTRS_W-1:0]    rsp_dat,
  output logic [LVL_W-1:0]      level_r,
  output logic                  full,
  input  logic                  ovf_clr,
  output logic                  ovf_r,
  output logic [15:0]           drop_cnt_r
);

  localparam int IDX_W = LVL_W - 1;

  logic [CNTRS_ID_W-1:0] id_mem  [DEPTH];
  logic [CNTRS_W-1:0]    dat_mem [DEPTH];

  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic empty;
  logic ptr_full;
  logic push;
  logic pop;
  logic wr_en;
  logic drop;

  assign wr_idx   = wr_ptr[IDX_W-1:0];
  assign rd_idx   = rd_ptr[IDX_W-1:0];
  assign empty    = (wr_ptr == rd_ptr);
  assign ptr_full = (wr_idx == rd_idx) &&
                    (wr_ptr[LVL_W-1] != rd_ptr[LVL_W-1]);

  assign push  = status_pass & status_qry;
  assign pop   = rsp_vld & rsp_rdy;
  // A pop in the same cycle frees the slot, so a push at full is kept.
  assign wr_en = push & (~ptr_full | pop);
  assign drop  = push & ptr_full & ~pop;

  assign rsp_vld = ~empty;
  assign rsp_id  = id_mem[rd_idx];
  assign rsp_dat = dat_mem[rd_idx];
  assign full    = (level_r == LVL_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      id_mem[wr_idx]  <= status_id;
      dat_mem[wr_idx] <= status_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + LVL_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + LVL_W'(1);
      if (wr_en && !pop)
        level_r <= level_r + LVL_W'(1);
      else if (pop && !wr_en)
        level_r <= level_r - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ovf_r <= 1'b0;
    else if (drop)
      ovf_r <= 1'b1;
    else if (ovf_clr)
      ovf_r <= 1'b0;
  end

`ifdef MULTI_COUNTER_RSP_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt_r <= '0;
    else if (drop) begin
      if (ovf_clr)
        drop_cnt_r <= 16'd1;
      else if (drop_cnt_r != 16'hFFFF)
        drop_cnt_r <= drop_cnt_r + 16'd1;
    end else if (ovf_clr)
      drop_cnt_r <= '0;
  end
`else
  assign drop_cnt_r = 16'h0;
`endif

endmodule

// File: tb/tb_multi_counter_rsp_fifo.sv
// Scoreboard bench for multi_counter_rsp_fifo.
// Directed vectors; monitor pops expected responses on each handshake.
module tb_multi_counter_rsp_fifo;

  localparam int DEPTH = 8;
  localparam int ID_W  = 8;
  localparam int DW    = 32;
  localparam int LVL_W = 4;

`ifdef MULTI_COUNTER_RSP_DROP_CNT_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            status_pass;
  logic            status_qry;
  logic [ID_W-1:0] status_id;
  logic [DW-1:0]   status_dat;
  logic            rsp_vld;
  logic            rsp_rdy;
  logic [ID_W-1:0] rsp_id;
  logic [DW-1:0]   rsp_dat;
  logic [LVL_W-1:0] level_r;
  logic            full;
  logic            ovf_clr;
  logic            ovf_r;
  logic [15:0]     drop_cnt_r;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   dat;
  } rsp_t;

  rsp_t q[$];

  always #5 clk = ~clk;

  multi_counter_rsp_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .status_pass (status_pass),
    .status_qry  (status_qry),
    .status_id   (status_id),
    .status_dat  (status_dat),
    .rsp_vld     (rsp_vld),
    .rsp_rdy     (rsp_rdy),
    .rsp_id      (rsp_id),
    .rsp_dat     (rsp_dat),
    .level_r     (level_r),
    .full        (full),
    .ovf_clr     (ovf_clr),
    .ovf_r       (ovf_r),
    .drop_cnt_r  (drop_cnt_r)
  );

  always @(negedge clk) begin
    if (!rst && rsp_vld && rsp_rdy) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected act id=%0h dat=%0h exp none",
                 rsp_id, rsp_dat);
      end else begin
        rsp_t e;
        e = q.pop_front();
        if (rsp_id !== e.id || rsp_dat !== e.dat) begin
          errors++;
          $display("FAIL rsp_order act id=%0h dat=%0h exp id=%0h dat=%0h",
                   rsp_id, rsp_dat, e.id, e.dat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [ID_W-1:0] id, logic [DW-1:0] dat, bit acc);
    status_pass = 1'b1;
    status_qry  = 1'b1;
    status_id   = id;
    status_dat  = dat;
    if (acc) q.push_back('{id: id, dat: dat});
  endtask

  task automatic idle();
    status_pass = 1'b0;
    status_qry  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int sent;
    rst = 1'b1;
    status_pass = 1'b0;
    status_qry = 1'b0;
    status_id = '0;
    status_dat = '0;
    rsp_rdy = 1'b0;
    ovf_clr = 1'b0;
    tick();
    tick();
    chk("rst_vld", 32'(rsp_vld), 0);
    chk("rst_level", 32'(level_r), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(ovf_r), 0);
    chk("rst_drop", 32'(drop_cnt_r), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_vld", 32'(rsp_vld), 0);

    // single push, one-cycle latency
    rsp_rdy = 1'b1;
    drive(8'd5, 32'h1234, 1'b1);
    tick();
    idle();
    chk("t1_vld", 32'(rsp_vld), 1);
    chk("t1_id", 32'(rsp_id), 5);
    chk("t1_dat", rsp_dat, 32'h1234);
    tick();
    chk("t1_empty", 32'(rsp_vld), 0);
    chk("t1_level", 32'(level_r), 0);

    // pass without qry is not a response
    status_pass = 1'b1;
    status_qry  = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    idle();
    chk("t2_level", 32'(level_r), 0);
    chk("t2_vld", 32'(rsp_vld), 0);

    // overflow by one
    rsp_rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(8'(16 + i), 32'hA000 + 32'(i), i < 8);
      tick();
    end
    idle();
    chk("t3_full", 32'(full), 1);
    chk("t3_level", 32'(level_r), 8);
    chk("t3_ovf", 32'(ovf_r), 1);
    chk("t3_drop", 32'(drop_cnt_r), DC ? 1 : 0);
    rsp_rdy = 1'b1;
    repeat (8) tick();
    chk("t3_drained", 32'(level_r), 0);

    // push and pop together while full
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(ovf_r), 0);
    rsp_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(8'(32 + i), 32'hB000 + 32'(i), 1'b1);
      tick();
    end
    rsp_rdy = 1'b1;
    drive(8'd40, 32'hBEEF, 1'b1);
    tick();
    idle();
    chk("t4_level", 32'(level_r), 8);
    chk("t4_full", 32'(full), 1);
    chk("t4_ovf", 32'(ovf_r), 0);
    repeat (8) tick();
    chk("t4_drained", 32'(level_r), 0);

    // many drops, then clear racing a drop
    rsp_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(8'(48 + i), 32'hC000 + 32'(i), 1'b1);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(8'd99, 32'hDEAD, 1'b0);
      tick();
    end
    chk("t5_ovf20", 32'(ovf_r), 1);
    chk("t5_drop20", 32'(drop_cnt_r), DC ? 20 : 0);
    ovf_clr = 1'b1;
    tick();
    chk("t5_clr_drop_ovf", 32'(ovf_r), 1);
    chk("t5_clr_drop_cnt", 32'(drop_cnt_r), DC ? 1 : 0);
    idle();
    tick();
    ovf_clr = 1'b0;
    chk("t5_clr_ovf", 32'(ovf_r), 0);
    chk("t5_clr_cnt", 32'(drop_cnt_r), 0);
    chk("t5_head_kept", 32'(rsp_id), 48);
    rsp_rdy = 1'b1;
    repeat (8) tick();
    chk("t5_drained", 32'(level_r), 0);

    // pointer wrap with random backpressure
    sent = 0;
    cyc = 0;
    while (sent < 3 * DEPTH + 3 && cyc < 2000) begin
      rsp_rdy = 1'($urandom_range(0, 1));
      if (q.size() < 6) begin
        drive(8'(64 + sent), 32'hE000 + 32'(sent), 1'b1);
        sent++;
      end else begin
        idle();
      end
      tick();
      cyc++;
    end
    idle();
    rsp_rdy = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("t6_sent", 32'(sent), 3 * DEPTH + 3);
    chk("t6_q_empty", 32'(q.size()), 0);
    tick();
    chk("t6_level", 32'(level_r), 0);
    chk("t6_ovf", 32'(ovf_r), 0);

    // reset flushes a partly full fifo
    rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'(96 + i), 32'hF000 + 32'(i), 1'b1);
      tick();
    end
    idle();
    chk("t6_level5", 32'(level_r), 5);
    rst = 1'b1;
    tick();
    q.delete();
    chk("t6_rst_vld", 32'(rsp_vld), 0);
    chk("t6_rst_level", 32'(level_r), 0);
    rst = 1'b0;
    rsp_rdy = 1'b1;
    tick();
    chk("t6_post_rst_vld", 32'(rsp_vld), 0);
    chk("t6_post_rst_full", 32'(full), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
